// File: rtl/lime_io_pkg.sv
// Shared definitions for the lime processor I/O blocks.
//   LIME_WORD_WIDTH    : processor word width
//   LIME_CAPTURE_DEPTH : default output-capture FIFO depth
//   lime_word_t        : one processor word
package lime_io_pkg;

    localparam int unsigned LIME_WORD_WIDTH    = 16;
    localparam int unsigned LIME_CAPTURE_DEPTH = 4;

    typedef logic [LIME_WORD_WIDTH-1:0] lime_word_t;

endpackage

// File: rtl/lime_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous circular FIFO.
// A push while full is still accepted when a pop happens in the same cycle,
// with the new word landing in the slot freed by the read.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : push request and data
//   pop           : pop request (caller guarantees non-empty)
//   rdata         : head entry (registered storage, combinational read)
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
//   push_ok       : push request accepted this cycle
module lime_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign rdata   = mem[rd_ptr];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lime_output_capture.sv
// Capture stage for the processor main_output bus. Every change of the bus
// (while capture_en is high) is queued in a small FIFO that a host drains
// over a valid/ready handshake. Dropped changes set a sticky overflow flag.
// Ports:
//   CLK, reset      : clock, asynchronous active-high reset
//   proc_output     : processor main_output
//   capture_en      : enable enqueueing of detected changes
//   out_data        : FIFO head entry (don't-care when out_valid is 0)
//   out_valid       : FIFO non-empty
//   out_ready       : consumer accepts head entry
//   count           : FIFO occupancy, 0..DEPTH
//   overflow        : sticky, set when a change is dropped
//   clear_overflow  : synchronous clear of overflow (set wins)
module lime_output_capture
    import lime_io_pkg::*;
#(
    parameter int unsigned WIDTH = LIME_WORD_WIDTH,
    parameter int unsigned DEPTH = LIME_CAPTURE_DEPTH
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       proc_output,
    input  logic                   capture_en,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    logic [WIDTH-1:0] prev_value;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // prev_value tracks the bus regardless of capture_en, so a change seen
    // while capture is disabled is lost for good.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prev_value <= '0;
        end else begin
            prev_value <= proc_output;
        end
    end

    assign push_req  = capture_en && (proc_output != prev_value);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && !push_ok) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    lime_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (reset),
        .push    (push_req),
        .wdata   (proc_output),
        .pop     (pop),
        .rdata   (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count),
        .push_ok (push_ok)
    );

    // full is implied by push_ok; kept on the FIFO interface for other users.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_lime_output_capture.sv
module tb_lime_output_capture;
    import lime_io_pkg::*;

    logic       CLK = 1'b0;
    logic       reset;
    lime_word_t proc_output;
    logic       capture_en;
    lime_word_t out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clear_overflow;

    int checks = 0;
    int errors = 0;
    lime_word_t exp_q[$];

    lime_output_capture #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .proc_output    (proc_output),
        .capture_en     (capture_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_push(input lime_word_t v);
        proc_output = v;
        exp_q.push_back(v);
        step();
    endtask

    // Monitor: a transfer completes at the next rising edge whenever
    // out_valid && out_ready are seen at the falling edge.
    always @(negedge CLK) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got 0x%0h expected no output at %0t", out_data, $time);
            end else begin
                lime_word_t e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL drain_data: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        proc_output    = '0;
        capture_en     = 1'b1;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        step();
        step();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Constant zero: nothing captured
        repeat (5) step();
        check("zero_valid", 32'(out_valid), 32'd0);
        check("zero_count", 32'(count), 32'd0);

        // Three changes, no consumer
        drive_push(16'h0001);
        drive_push(16'h0002);
        drive_push(16'h0003);
        check("fill3_count", 32'(count), 32'd3);
        check("fill3_head", 32'(out_data), 32'h0001);

        // Drain
        out_ready = 1'b1;
        repeat (3) step();
        check("drain3_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Overflow: fifth value dropped
        drive_push(16'h0010);
        drive_push(16'h0011);
        drive_push(16'h0012);
        drive_push(16'h0013);
        proc_output = 16'h0014;
        step();
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();
        check("ovf_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Push while full with simultaneous pop
        drive_push(16'h0020);
        drive_push(16'h0021);
        drive_push(16'h0022);
        drive_push(16'h0023);
        check("full_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        exp_q.push_back(16'hBEEF);
        proc_output = 16'hBEEF;
        step();
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_overflow", 32'(overflow), 32'd0);
        check("fullpop_head", 32'(out_data), 32'h0021);

        // Drop and clear in same cycle: set wins
        out_ready = 1'b0;
        proc_output = 16'h1234;
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("set_wins_overflow", 32'(overflow), 32'd1);
        check("set_wins_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        repeat (4) step();
        check("beef_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;

        // capture_en low: change lost, later identical value not captured
        capture_en = 1'b0;
        proc_output = 16'h0040;
        step();
        capture_en = 1'b1;
        step();
        check("capen_count", 32'(count), 32'd0);

        // Asynchronous reset mid-operation
        drive_push(16'h0030);
        drive_push(16'h0031);
        check("prereset_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        step();
        reset = 1'b0;
        drive_push(16'h00AA);
        step();
        check("postreset_count", 32'(count), 32'd1);
        check("postreset_head", 32'(out_data), 32'h00AA);
        out_ready = 1'b1;
        step();
        check("postreset_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lime_output_capture.md
# lime_output_capture

Downstream capture stage for the 16-bit multi-cycle processor's `main_output` port. It watches the processor output bus every cycle and records each new value in a small FIFO, so a host or test harness can drain the full output sequence over a valid/ready handshake without missing values written faster than it polls. It sits between the processor top's `main_output` and the host-side consumer. It holds no processor state and generates no processor control.

## Interface
Parameters:
- `WIDTH`, 16: data width, equal to the processor word.
- `DEPTH`, 4: FIFO entries; must be a power of two and ≥ 2.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `proc_output`  in  WIDTH  connected to the processor's `main_output`.
- `capture_en`  in  1  enables enqueueing of detected changes.
- `out_data`  out  WIDTH  FIFO head entry.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a change is dropped.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- `prev_value` register: reset 0, loaded with `proc_output` every cycle, regardless of `capture_en`.
- Change detect (combinational): `push_req = capture_en && (proc_output != prev_value)`.
  - Consequence: a value equal to the previous one is never captured.
  - Consequence: a nonzero value present at reset release is captured on the first edge.
- Pop: `pop = out_valid && out_ready`.
- Push acceptance:
  - Accepted if `count < DEPTH`.
  - Also accepted if `count == DEPTH` and `pop` is high the same cycle. Count stays DEPTH; the new entry goes to the write slot freed by the read.
  - Otherwise the value is dropped, `overflow` ← 1, and the FIFO is unchanged.
- Storage: circular buffer, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Push writes `mem[wr_ptr]` ← `proc_output` and increments `wr_ptr`.
  - Pop increments `rd_ptr`.
- Occupancy: `count` updates by +1 on push only, −1 on pop only, and 0 on push+pop.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`, a registered entry read combinationally; `out_data` is don't-care when `out_valid` is 0.
- No bypass path: a value pushed into an empty FIFO is not visible until the next cycle.
- `overflow`:
  - Set by any dropped push.
  - Cleared by `clear_overflow`; a set and a clear in the same cycle resolve to set.
  - Remains 1 until it is cleared.
- Pop on empty is impossible, because `out_valid` is 0.

## Timing
- Reset (asynchronous, immediate): `prev_value`=0, pointers=0, `count`=0, `out_valid`=0, `overflow`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all queued entries. The first edge after release compares against 0.
- Capture latency: `proc_output` changes before edge N → entry written at edge N → `out_valid`=1 after edge N. That is 1 cycle.
- Handshake: a transfer completes at each rising edge where `out_valid && out_ready`. `out_data` advances to the next entry after that edge.
- Sustained throughput: one push and one pop per cycle.
- `out_valid` depends only on registered state. It has no combinational path from `out_ready` or `proc_output`.
- `capture_en` low for a cycle: a change in that cycle is lost permanently, because `prev_value` still updates.

## Structure
- Shared package `lime_io_pkg`:
  - `LIME_WORD_WIDTH` = 16.
  - `LIME_CAPTURE_DEPTH` = 4.
  - A `lime_word_t` typedef, shared with future I/O blocks.
- Sub-module `lime_sync_fifo`:
  - Generic DEPTH×WIDTH circular FIFO with push/pop, full/empty and count.
  - Implements the push-while-full-with-pop rule.
- `lime_output_capture` holds the change detector and overflow logic, and instantiates `lime_sync_fifo`.

## Test plan
- Reset, then drive `proc_output`=0x0000 with `capture_en`=1 for 5 cycles → `out_valid` stays 0, `count`=0.
- `out_ready`=0; drive 0x0001, 0x0002, 0x0003 on consecutive cycles → `count`=3 after the third edge; `out_data`=0x0001.
- With `out_ready`=1, drain → 0x0001, 0x0002, 0x0003 on consecutive edges; then `out_valid`=0.
- `out_ready`=0; drive 5 distinct values 0x0010..0x0014 → `count`=4; `overflow`=1 after the 5th edge. Drain yields 0x0010..0x0013.
- FIFO full with `out_ready`=1; drive a new value 0xBEEF → `count` stays 4, `overflow` stays 0, and 0xBEEF is the last entry drained. Then assert `clear_overflow` with a simultaneous drop → `overflow` stays 1.
- Load 2 entries, assert `reset` between clock edges → `out_valid`=0 and `count`=0 immediately. After release, drive 0x00AA → single entry 0x00AA.
